// File: rtl/cflog_writer_if.sv
// ----------------------------------------------------------------------------
// cflog_writer_if
//   Bundles the branch-monitor/TCB facing signals and the CFLog RAM write port
//   of cflog_writer.
//
//   master : the environment side (branch monitor, TCB, RAM); drives pc,
//            branch_detect and log_clr, observes the write port and status.
//   slave  : the cflog_writer side.
//
//   pc            16  current CPU program counter
//   branch_detect  1  one-cycle strobe from the branch monitor
//   log_clr        1  synchronous pulse: CFLog flushed, restart at word 0
//   log_wr_en      1  write strobe to the CFLog RAM
//   log_wr_addr   16  word address of the write
//   log_wr_data   16  word being written
//   log_ptr       16  words written since the last clear
//   log_full       1  no room left for a pair
//   branch_lost    1  sticky: a branch was dropped
// ----------------------------------------------------------------------------
interface cflog_writer_if;
    logic [15:0] pc;
    logic        branch_detect;
    logic        log_clr;
    logic        log_wr_en;
    logic [15:0] log_wr_addr;
    logic [15:0] log_wr_data;
    logic [15:0] log_ptr;
    logic        log_full;
    logic        branch_lost;

    modport master (
        output pc,
        output branch_detect,
        output log_clr,
        input  log_wr_en,
        input  log_wr_addr,
        input  log_wr_data,
        input  log_ptr,
        input  log_full,
        input  branch_lost
    );

    modport slave (
        input  pc,
        input  branch_detect,
        input  log_clr,
        output log_wr_en,
        output log_wr_addr,
        output log_wr_data,
        output log_ptr,
        output log_full,
        output branch_lost
    );
endinterface

// File: rtl/cflog_writer.sv
// ----------------------------------------------------------------------------
// cflog_writer
//   Captures (source, destination) PC pairs on each branch_detect strobe and
//   writes them, one 16-bit word per cycle, into the CFLog region. Maintains
//   the log pointer, the log_full flag used to trigger the flush NMI, and a
//   sticky branch_lost flag for branches dropped while busy or full.
//
// Parameters
//   LOG_SIZE  CFLog capacity in 16-bit words (even, >= 4)
//   LOG_BASE  word offset added to the pointer to form the write address
//
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    cflog_writer_if.slave: pc, branch_detect, log_clr in;
//          log_wr_en/addr/data, log_ptr, log_full, branch_lost out
//
// Configuration
//   CFLOG_LOOP_COMPRESS_EN  when defined, a pair identical to the last one
//                           written is counted instead of written; the count
//                           is flushed as a run record {16'h0000, run_cnt}
//                           ahead of the next differing pair, or as soon as
//                           it saturates at 16'hFFFF.
// ----------------------------------------------------------------------------
module cflog_writer #(
    parameter logic [15:0] LOG_SIZE = 16'h0040,
    parameter logic [15:0] LOG_BASE = 16'h0000
) (
    input logic           clk,
    input logic           rst_n,
    cflog_writer_if.slave bus
);

`ifdef CFLOG_LOOP_COMPRESS_EN
    typedef enum logic [2:0] {
        StIdle,
        StWaitDst,
        StWrSrc,
        StWrDst,
        StWrRun0,
        StWrRun1
    } state_t;
`else
    typedef enum logic [1:0] {
        StIdle,
        StWaitDst,
        StWrSrc,
        StWrDst
    } state_t;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_src;
    logic [15:0] r_dst;
    logic [15:0] r_ptr;
    logic        r_lost;

    logic        w_full;
    logic        w_room;
    logic        w_accept;
    logic        w_lost_set;
    logic        w_cap_dst;
    logic        w_wr_en;
    logic [15:0] w_wr_data;

`ifdef CFLOG_LOOP_COMPRESS_EN
    logic [15:0] r_run_cnt;
    logic [15:0] r_last_src;
    logic [15:0] r_last_dst;
    logic        w_repeat;
    logic        w_run_inc;
`endif

    // Full means fewer than two free words remain.
    assign w_full = (r_ptr > (LOG_SIZE - 16'd2));

`ifdef CFLOG_LOOP_COMPRESS_EN
    // A pending run record must fit together with the next pair, since the
    // pair may turn out to differ from the last one.
    assign w_room   = (r_run_cnt != 16'd0) ? (r_ptr <= (LOG_SIZE - 16'd4)) : !w_full;
    // A zero last_src never matches: address 0 is not a valid source PC.
    assign w_repeat = (r_src == r_last_src) && (bus.pc == r_last_dst);
`else
    assign w_room = !w_full;
`endif

    assign w_accept   = bus.branch_detect && !bus.log_clr && (r_state == StIdle) && w_room;
    assign w_lost_set = bus.branch_detect && !bus.log_clr && !((r_state == StIdle) && w_room);

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_wr_data   = 16'd0;
        w_cap_dst   = 1'b0;
`ifdef CFLOG_LOOP_COMPRESS_EN
        w_run_inc   = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_nxt = StWaitDst;
                end
            end
            StWaitDst: begin
                // PC holds its value through multi-cycle instructions.
                if (bus.pc != r_src) begin
                    w_cap_dst = 1'b1;
`ifdef CFLOG_LOOP_COMPRESS_EN
                    if (w_repeat) begin
                        w_run_inc   = 1'b1;
                        w_state_nxt = (r_run_cnt == 16'hFFFE) ? StWrRun0 : StIdle;
                    end else if (r_run_cnt != 16'd0) begin
                        w_state_nxt = StWrRun0;
                    end else begin
                        w_state_nxt = StWrSrc;
                    end
`else
                    w_state_nxt = StWrSrc;
`endif
                end
            end
            StWrSrc: begin
                w_wr_en     = 1'b1;
                w_wr_data   = r_src;
                w_state_nxt = StWrDst;
            end
            StWrDst: begin
                w_wr_en     = 1'b1;
                w_wr_data   = r_dst;
                w_state_nxt = StIdle;
            end
`ifdef CFLOG_LOOP_COMPRESS_EN
            StWrRun0: begin
                w_wr_en     = 1'b1;
                w_wr_data   = 16'h0000;
                w_state_nxt = StWrRun1;
            end
            StWrRun1: begin
                w_wr_en     = 1'b1;
                w_wr_data   = r_run_cnt;
                // A saturated run is flushed on its own, with no pair behind it.
                w_state_nxt = (r_run_cnt == 16'hFFFF) ? StIdle : StWrSrc;
            end
`endif
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // Clear wins over everything, including a write already in progress.
        if (bus.log_clr) begin
            w_state_nxt = StIdle;
            w_wr_en     = 1'b0;
            w_wr_data   = 16'd0;
            w_cap_dst   = 1'b0;
`ifdef CFLOG_LOOP_COMPRESS_EN
            w_run_inc   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_src      <= 16'd0;
            r_dst      <= 16'd0;
            r_ptr      <= 16'd0;
            r_lost     <= 1'b0;
`ifdef CFLOG_LOOP_COMPRESS_EN
            r_run_cnt  <= 16'd0;
            r_last_src <= 16'd0;
            r_last_dst <= 16'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (bus.log_clr) begin
                r_ptr      <= 16'd0;
                r_lost     <= 1'b0;
`ifdef CFLOG_LOOP_COMPRESS_EN
                r_run_cnt  <= 16'd0;
                r_last_src <= 16'd0;
                r_last_dst <= 16'd0;
`endif
            end else begin
                if (w_accept) begin
                    r_src <= bus.pc;
                end
                if (w_cap_dst) begin
                    r_dst <= bus.pc;
                end
                if (w_wr_en) begin
                    r_ptr <= r_ptr + 16'd1;
                end
                if (w_lost_set) begin
                    r_lost <= 1'b1;
                end
`ifdef CFLOG_LOOP_COMPRESS_EN
                if (w_run_inc) begin
                    r_run_cnt <= r_run_cnt + 16'd1;
                end else if (r_state == StWrRun1) begin
                    r_run_cnt <= 16'd0;
                end
                if (r_state == StWrDst) begin
                    r_last_src <= r_src;
                    r_last_dst <= r_dst;
                end
`endif
            end
        end
    end

    // Address and data are held at 0 when not writing so reset leaves every
    // output at 0 regardless of LOG_BASE.
    assign bus.log_wr_en   = w_wr_en;
    assign bus.log_wr_addr = w_wr_en ? (LOG_BASE + r_ptr) : 16'd0;
    assign bus.log_wr_data = w_wr_data;
    assign bus.log_ptr     = r_ptr;
    assign bus.log_full    = w_full;
    assign bus.branch_lost = r_lost;

endmodule

// File: tb/tb_cflog_writer.sv
// ----------------------------------------------------------------------------
// tb_cflog_writer
//   Self-checking bench for cflog_writer. Two instances: a main one
//   (LOG_SIZE 0x40, LOG_BASE 0x0100) and a small one (LOG_SIZE 4,
//   LOG_BASE 0x0020) for the full-log cases. Expected writes are queued per
//   instance when stimulus is driven and compared by a monitor on each write.
// ----------------------------------------------------------------------------
module tb_cflog_writer;

    localparam logic [15:0] BaseM = 16'h0100;
    localparam logic [15:0] BaseS = 16'h0020;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic        bd;
    logic        clr;
    logic        sel;

    int n_chk;
    int n_err;

    logic [31:0] q_m[$];
    logic [31:0] q_s[$];
    logic [15:0] ptr_m;
    logic [15:0] ptr_s;

    cflog_writer_if if_m ();
    cflog_writer_if if_s ();

    assign if_m.pc            = pc;
    assign if_m.branch_detect = sel ? 1'b0 : bd;
    assign if_m.log_clr       = sel ? 1'b0 : clr;
    assign if_s.pc            = pc;
    assign if_s.branch_detect = sel ? bd : 1'b0;
    assign if_s.log_clr       = sel ? clr : 1'b0;

    cflog_writer #(
        .LOG_SIZE (16'h0040),
        .LOG_BASE (BaseM)
    ) u_dut_m (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_m)
    );

    cflog_writer #(
        .LOG_SIZE (16'h0004),
        .LOG_BASE (BaseS)
    ) u_dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_s)
    );

    logic        cur_wr_en;
    logic [15:0] cur_ptr;
    logic        cur_full;
    logic        cur_lost;
    assign cur_wr_en = sel ? if_s.log_wr_en   : if_m.log_wr_en;
    assign cur_ptr   = sel ? if_s.log_ptr     : if_m.log_ptr;
    assign cur_full  = sel ? if_s.log_full    : if_m.log_full;
    assign cur_lost  = sel ? if_s.branch_lost : if_m.branch_lost;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [15:0] data);
        if (sel) begin
            q_s.push_back({BaseS + ptr_s, data});
            ptr_s = ptr_s + 16'd1;
        end else begin
            q_m.push_back({BaseM + ptr_m, data});
            ptr_m = ptr_m + 16'd1;
        end
    endtask

    // One branch: detect at src, hold pc for `hold` cycles, then move to dst.
    // Optional extra detects while busy in WAIT_DST and in WR_DST.
    task automatic branch(input logic [15:0] src, input logic [15:0] dst, input int hold,
                          input bit drop_wait, input bit drop_wrdst, input bit exp_wr);
        if (exp_wr) begin
            push_wr(src);
            push_wr(dst);
        end
        pc = src;
        bd = 1'b1;
        tick();
        bd = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (drop_wait && (i == 0)) bd = 1'b1;
            tick();
            bd = 1'b0;
            check_eq("hold_no_wr", 32'(cur_wr_en), 32'd0);
        end
        pc = dst;
        tick();
        check_eq("wr_src_en", 32'(cur_wr_en), 32'(exp_wr));
        tick();
        check_eq("wr_dst_en", 32'(cur_wr_en), 32'(exp_wr));
        if (drop_wrdst) bd = 1'b1;
        tick();
        bd = 1'b0;
    endtask

    always @(negedge clk) begin : mon_m
        logic [31:0] e;
        if (rst_n && if_m.log_wr_en) begin
            check_eq("m_wr_expected", 32'(q_m.size() != 0), 32'd1);
            if (q_m.size() != 0) begin
                e = q_m.pop_front();
                check_eq("m_wr", {if_m.log_wr_addr, if_m.log_wr_data}, e);
            end
        end
    end

    always @(negedge clk) begin : mon_s
        logic [31:0] e;
        if (rst_n && if_s.log_wr_en) begin
            check_eq("s_wr_addr_bound", 32'(if_s.log_wr_addr < (BaseS + 16'd4)), 32'd1);
            check_eq("s_wr_expected", 32'(q_s.size() != 0), 32'd1);
            if (q_s.size() != 0) begin
                e = q_s.pop_front();
                check_eq("s_wr", {if_s.log_wr_addr, if_s.log_wr_data}, e);
            end
        end
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        ptr_m = 16'd0;
        ptr_s = 16'd0;
        rst_n = 1'b0;
        pc    = 16'd0;
        bd    = 1'b0;
        clr   = 1'b0;
        sel   = 1'b0;
        #2;
        check_eq("rst_wr_en", 32'(if_m.log_wr_en), 32'd0);
        check_eq("rst_addr", 32'(if_m.log_wr_addr), 32'd0);
        check_eq("rst_data", 32'(if_m.log_wr_data), 32'd0);
        check_eq("rst_ptr", 32'(if_m.log_ptr), 32'd0);
        check_eq("rst_full", 32'(if_m.log_full), 32'd0);
        check_eq("rst_lost", 32'(if_m.branch_lost), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // T1: reset in the middle of WR_SRC, then a clean pair.
        pc = 16'hE010;
        bd = 1'b1;
        tick();
        bd = 1'b0;
        pc = 16'hE200;
        tick();
        check_eq("t1_in_wr_src", 32'(if_m.log_wr_en), 32'd1);
        check_eq("t1_src_word", {if_m.log_wr_addr, if_m.log_wr_data}, {BaseM, 16'hE010});
        rst_n = 1'b0;
        #1;
        check_eq("t1_rst_wr_en", 32'(if_m.log_wr_en), 32'd0);
        check_eq("t1_rst_addr", 32'(if_m.log_wr_addr), 32'd0);
        check_eq("t1_rst_data", 32'(if_m.log_wr_data), 32'd0);
        check_eq("t1_rst_ptr", 32'(if_m.log_ptr), 32'd0);
        check_eq("t1_rst_full", 32'(if_m.log_full), 32'd0);
        check_eq("t1_rst_lost", 32'(if_m.branch_lost), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        branch(16'hE010, 16'hE200, 0, 1'b0, 1'b0, 1'b1);
        check_eq("t1_ptr", 32'(cur_ptr), 32'd2);

        // T2: pc held for three cycles before the destination appears.
        branch(16'hE010, 16'hE300, 3, 1'b0, 1'b0, 1'b1);
        check_eq("t2_ptr", 32'(cur_ptr), 32'(ptr_m));
        check_eq("t2_lost", 32'(cur_lost), 32'd0);

        // T4: detects while in WAIT_DST and WR_DST are dropped.
        branch(16'hE400, 16'hE500, 1, 1'b1, 1'b1, 1'b1);
        pc = 16'hE600;
        repeat (4) tick();
        check_eq("t4_lost", 32'(cur_lost), 32'd1);
        check_eq("t4_ptr", 32'(cur_ptr), 32'd6);

        // T5: clear during WR_SRC together with a detect.
        pc = 16'hE700;
        bd = 1'b1;
        tick();
        bd = 1'b0;
        pc = 16'hE800;
        tick();
        clr = 1'b1;
        bd  = 1'b1;
        #1;
        check_eq("t5_clr_no_wr", 32'(cur_wr_en), 32'd0);
        tick();
        clr = 1'b0;
        bd  = 1'b0;
        ptr_m = 16'd0;
        check_eq("t5_ptr", 32'(cur_ptr), 32'd0);
        check_eq("t5_lost", 32'(cur_lost), 32'd0);
        check_eq("t5_wr_en", 32'(cur_wr_en), 32'd0);
        pc = 16'hEB00;
        repeat (4) tick();
        branch(16'hE900, 16'hEA00, 0, 1'b0, 1'b0, 1'b1);
        check_eq("t5_ptr_after", 32'(cur_ptr), 32'd2);

        // T3: small log fills after two pairs, third branch is lost.
        sel = 1'b1;
        tick();
        branch(16'hE010, 16'hE020, 0, 1'b0, 1'b0, 1'b1);
        check_eq("t3_ptr2", 32'(cur_ptr), 32'd2);
        check_eq("t3_full_at_2", 32'(cur_full), 32'd0);
        branch(16'hE030, 16'hE040, 1, 1'b0, 1'b0, 1'b1);
        check_eq("t3_ptr4", 32'(cur_ptr), 32'd4);
        check_eq("t3_full_at_4", 32'(cur_full), 32'd1);
        check_eq("t3_lost_before", 32'(cur_lost), 32'd0);
        branch(16'hE050, 16'hE060, 0, 1'b0, 1'b0, 1'b0);
        check_eq("t3_lost", 32'(cur_lost), 32'd1);
        check_eq("t3_ptr_held", 32'(cur_ptr), 32'd4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ptr_s = 16'd0;
        check_eq("t3_clr_ptr", 32'(cur_ptr), 32'd0);
        check_eq("t3_clr_full", 32'(cur_full), 32'd0);
        check_eq("t3_clr_lost", 32'(cur_lost), 32'd0);

`ifdef CFLOG_LOOP_COMPRESS_EN
        // T6: five identical pairs then a new one.
        sel = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ptr_m = 16'd0;
        branch(16'hE010, 16'hE000, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            branch(16'hE010, 16'hE000, 0, 1'b0, 1'b0, 1'b0);
        end
        check_eq("t6_ptr_mid", 32'(cur_ptr), 32'd2);
        push_wr(16'h0000);
        push_wr(16'h0004);
        push_wr(16'hE020);
        push_wr(16'hE100);
        pc = 16'hE020;
        bd = 1'b1;
        tick();
        bd = 1'b0;
        pc = 16'hE100;
        repeat (7) tick();
        check_eq("t6_ptr", 32'(cur_ptr), 32'd6);
`endif

        repeat (2) tick();
        check_eq("m_queue_empty", 32'(q_m.size()), 32'd0);
        check_eq("s_queue_empty", 32'(q_s.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
